// File: rtl/vga_timing_pkg.sv
// Shared timing constants, region encoding and total-length helper for the VGA core.
// The defaults describe standard 640x480 at 60 Hz.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        REG_ACT,
        REG_FP,
        REG_SYNC,
        REG_BP
    } region_e;

    function automatic int calcTotal(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_tick_gen.sv
// Pixel-rate clock enable: one registered clk-wide pulse every CLK_DIV clocks while enabled.
// The divider phase restarts from zero whenever the core is reset or disabled.
module vga_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic pix_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] divCnt_q, divCnt_d;
    logic          tick_q, tick_d;

    // The pulse is registered, so the first tick lands CLK_DIV clocks after enable rises.
    always_comb begin
        divCnt_d = divCnt_q;
        tick_d   = 1'b0;
        if (rst || !enable) begin
            divCnt_d = '0;
        end else begin
            tick_d   = (divCnt_q == DIV_LAST);
            divCnt_d = tick_d ? '0 : divCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        divCnt_q <= divCnt_d;
        tick_q   <= tick_d;
    end

    assign pix_tick = tick_q;

endmodule

// File: rtl/vga_video_core.sv
// VGA timing core: pixel enable, H/V counters and region FSMs, sync generation and a
// pixel-tick alignment pipe so syncs and colour leave together, PIPE_LAT+1 ticks late.
module vga_video_core
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   CLK_DIV  = 2,
    parameter int   RGB_W    = 3,
    parameter int   PIPE_LAT = 0,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    localparam int  H_TOTAL  = calcTotal(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int  V_TOTAL  = calcTotal(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int  HW       = $clog2(H_TOTAL),
    localparam int  VW       = $clog2(V_TOTAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [HW-1:0]    hcount,
    output logic [VW-1:0]    vcount,
    output logic             pix_tick,
    output logic             line_start,
    output logic             frame_start,
    output logic             HSync,
    output logic             VSync,
    output logic [RGB_W-1:0] rgb
);

    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_FP_END   = HW'(H_ACTIVE + H_FP - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_FP_END   = VW'(V_ACTIVE + V_FP - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    logic tick;
    logic clear;
    logic lineWrap;

    logic [HW-1:0] hCount_q, hCount_d;
    logic [VW-1:0] vCount_q, vCount_d;
    region_e       hState_q, hState_d;
    region_e       vState_q, vState_d;

    vga_tick_gen #(.CLK_DIV(CLK_DIV)) u_tickGen (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .pix_tick (tick)
    );

    assign clear    = rst || !enable;
    assign lineWrap = tick && (hCount_q == H_LAST);

    // Counters and region FSMs move only on the pixel tick; vertical moves only on line wrap.
    always_comb begin
        hCount_d = hCount_q;
        vCount_d = vCount_q;
        hState_d = hState_q;
        vState_d = vState_q;
        if (clear) begin
            hCount_d = '0;
            vCount_d = '0;
            hState_d = REG_ACT;
            vState_d = REG_ACT;
        end else if (tick) begin
            hCount_d = lineWrap ? '0 : hCount_q + 1'b1;
            case (hState_q)
                REG_ACT:  if (hCount_q == H_ACT_END)  hState_d = REG_FP;
                REG_FP:   if (hCount_q == H_FP_END)   hState_d = REG_SYNC;
                REG_SYNC: if (hCount_q == H_SYNC_END) hState_d = REG_BP;
                REG_BP:   if (hCount_q == H_LAST)     hState_d = REG_ACT;
                default:                              hState_d = REG_ACT;
            endcase
            if (lineWrap) begin
                vCount_d = (vCount_q == V_LAST) ? '0 : vCount_q + 1'b1;
                case (vState_q)
                    REG_ACT:  if (vCount_q == V_ACT_END)  vState_d = REG_FP;
                    REG_FP:   if (vCount_q == V_FP_END)   vState_d = REG_SYNC;
                    REG_SYNC: if (vCount_q == V_SYNC_END) vState_d = REG_BP;
                    REG_BP:   if (vCount_q == V_LAST)     vState_d = REG_ACT;
                    default:                              vState_d = REG_ACT;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        hCount_q <= hCount_d;
        vCount_q <= vCount_d;
        hState_q <= hState_d;
        vState_q <= vState_d;
    end

    // Bit 2 = video_on, bit 1 = vsync active, bit 0 = hsync active.
    logic [2:0] rawSig;
    logic [2:0] tapSig;

    assign rawSig = {(hState_q == REG_ACT) && (vState_q == REG_ACT),
                     (vState_q == REG_SYNC),
                     (hState_q == REG_SYNC)};

    generate
        if (PIPE_LAT == 0) begin : g_noPipe
            assign tapSig = rawSig;
        end else begin : g_pipe
            logic [2:0] dly_q [PIPE_LAT];

            always_ff @(posedge clk) begin
                if (clear) begin
                    for (int i = 0; i < PIPE_LAT; i++) dly_q[i] <= '0;
                end else if (tick) begin
                    dly_q[0] <= rawSig;
                    for (int i = 1; i < PIPE_LAT; i++) dly_q[i] <= dly_q[i-1];
                end
            end

            assign tapSig = dly_q[PIPE_LAT-1];
        end
    endgenerate

    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hsPin_q, hsPin_d;
    logic             vsPin_q, vsPin_d;

    // Pin levels are registered directly so polarity inversion adds no logic after the flop.
    always_comb begin
        rgb_d   = rgb_q;
        hsPin_d = hsPin_q;
        vsPin_d = vsPin_q;
        if (clear) begin
            rgb_d   = '0;
            hsPin_d = ~HS_POL;
            vsPin_d = ~VS_POL;
        end else if (tick) begin
            rgb_d   = tapSig[2] ? rgb_in : '0;
            hsPin_d = tapSig[0] ? HS_POL : ~HS_POL;
            vsPin_d = tapSig[1] ? VS_POL : ~VS_POL;
        end
    end

    always_ff @(posedge clk) begin
        rgb_q   <= rgb_d;
        hsPin_q <= hsPin_d;
        vsPin_q <= vsPin_d;
    end

    assign hcount      = hCount_q;
    assign vcount      = vCount_q;
    assign pix_tick    = tick;
    assign line_start  = tick && (hCount_q == '0);
    assign frame_start = line_start && (vCount_q == '0);
    assign HSync       = hsPin_q;
    assign VSync       = vsPin_q;
    assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_video_core.sv
// Directed bench: a default 640x480 core (one measured line, restart, idle) and a tiny
// 12x7 core with positive syncs, CLK_DIV=1 and a 3-tick pixel source, checked per clock.
module tb_vga_video_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Default-timing instance
   logic       rstA = 1'b1, enA = 1'b0;
   logic [9:0] hcA, vcA;
   logic       tickA, lsA, fsA, hsA, vsA;
   logic [2:0] rgbA;

   vga_video_core dutA (
      .clk(clk), .rst(rstA), .enable(enA), .rgb_in(3'b111),
      .hcount(hcA), .vcount(vcA), .pix_tick(tickA), .line_start(lsA),
      .frame_start(fsA), .HSync(hsA), .VSync(vsA), .rgb(rgbA)
   );

   // Small-timing instance
   logic       rstB = 1'b1, enB = 1'b0;
   logic [3:0] hcB;
   logic [2:0] vcB;
   logic       tickB, lsB, fsB, hsB, vsB;
   logic [2:0] rgbB, rgbInB, s1, s2;

   vga_video_core #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .CLK_DIV(1), .PIPE_LAT(3), .HS_POL(1'b1), .VS_POL(1'b1)
   ) dutB (
      .clk(clk), .rst(rstB), .enable(enB), .rgb_in(rgbInB),
      .hcount(hcB), .vcount(vcB), .pix_tick(tickB), .line_start(lsB),
      .frame_start(fsB), .HSync(hsB), .VSync(vsB), .rgb(rgbB)
   );

   // Pixel source with a three-tick latency, returning hcount[2:0]
   always @(posedge clk) begin
      if (rstB || !enB) begin
         s1 <= '0; s2 <= '0; rgbInB <= '0;
      end else if (tickB) begin
         s1 <= hcB[2:0]; s2 <= s1; rgbInB <= s2;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input bit toB, input logic r, input logic e);
      if (toB) begin rstB = r; enB = e; end
      else     begin rstA = r; enA = e; end
   endtask

   initial begin
      int ticks, lsCnt, rgbOn, hsLow, vsLow, firstLowH;
      logic [2:0] rgbFirst;
      bit found;

      // Reset values, default instance
      repeat (3) @(negedge clk);
      checkOutput("A_rst_hcount", hcA, 0);
      checkOutput("A_rst_vcount", vcA, 0);
      checkOutput("A_rst_tick", tickA, 0);
      checkOutput("A_rst_ls", lsA, 0);
      checkOutput("A_rst_fs", fsA, 0);
      checkOutput("A_rst_rgb", rgbA, 0);
      checkOutput("A_rst_hs", hsA, 1);
      checkOutput("A_rst_vs", vsA, 1);

      // First tick two clocks after enable
      applyStimulus(0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("A_e1_tick", tickA, 0);
      checkOutput("A_e1_fs", fsA, 0);
      @(negedge clk);
      checkOutput("A_e2_tick", tickA, 1);
      checkOutput("A_e2_fs", fsA, 1);
      checkOutput("A_e2_ls", lsA, 1);
      checkOutput("A_e2_hcount", hcA, 0);
      checkOutput("A_e2_rgb", rgbA, 0);

      // Measure exactly one line
      ticks = 0; lsCnt = 0; rgbOn = 0; hsLow = 0; vsLow = 0; firstLowH = -1; rgbFirst = '0;
      for (int m = 1; m <= 1600; m++) begin
         @(negedge clk);
         if (m == 1) rgbFirst = rgbA;
         if (tickA) ticks++;
         if (lsA) lsCnt++;
         if (rgbA == 3'b111) rgbOn++;
         if (!vsA) vsLow++;
         if (!hsA) begin
            hsLow++;
            if (firstLowH < 0) firstLowH = int'(hcA);
         end
      end
      checkOutput("A_rgb_first", rgbFirst, 7);
      checkOutput("A_ticks_line", ticks, 800);
      checkOutput("A_ls_line", lsCnt, 1);
      checkOutput("A_rgb_clks", rgbOn, 1280);
      checkOutput("A_hs_clks", hsLow, 192);
      checkOutput("A_hs_first_h", firstLowH, 657);
      checkOutput("A_vs_clks", vsLow, 0);
      checkOutput("A_wrap_hcount", hcA, 0);
      checkOutput("A_wrap_vcount", vcA, 1);
      checkOutput("A_wrap_ls", lsA, 1);

      // Mid-line reset at hcount 300
      found = 0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk);
         if (hcA == 10'd300) found = 1;
      end
      checkOutput("A_reach300", found, 1);
      checkOutput("A_reach300_v", vcA, 1);
      applyStimulus(0, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("A_mrst_hcount", hcA, 0);
      checkOutput("A_mrst_vcount", vcA, 0);
      checkOutput("A_mrst_tick", tickA, 0);
      checkOutput("A_mrst_rgb", rgbA, 0);
      checkOutput("A_mrst_hs", hsA, 1);
      checkOutput("A_mrst_vs", vsA, 1);
      applyStimulus(0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("A_rel1_fs", fsA, 0);
      @(negedge clk);
      checkOutput("A_rel2_fs", fsA, 1);
      repeat (3) @(negedge clk);
      checkOutput("A_rel5_hcount", hcA, 2);
      checkOutput("A_rel5_rgb", rgbA, 7);

      // Enable low returns to idle on the next edge
      applyStimulus(0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("A_idle_hcount", hcA, 0);
      checkOutput("A_idle_tick", tickA, 0);
      checkOutput("A_idle_rgb", rgbA, 0);
      checkOutput("A_idle_hs", hsA, 1);

      // Small instance: idle levels with positive polarity
      checkOutput("B_rst_hs", hsB, 0);
      checkOutput("B_rst_vs", vsB, 0);
      checkOutput("B_rst_tick", tickB, 0);
      applyStimulus(1, 1'b0, 1'b1);
      for (int n = 1; n <= 200; n++) begin
         int t, hc, vc, p, hp, vp, expRgb, expHs, expVs;
         @(negedge clk);
         t = n - 1;
         hc = t % 12;
         vc = (t / 12) % 7;
         p = n - 5;
         expRgb = 0; expHs = 0; expVs = 0;
         if (p >= 0) begin
            hp = p % 12;
            vp = (p / 12) % 7;
            if (hp < 8 && vp < 4) expRgb = hp;
            expHs = (hp == 9 || hp == 10) ? 1 : 0;
            expVs = (vp == 5) ? 1 : 0;
         end
         checkOutput("B_tick", tickB, 1);
         checkOutput("B_hcount", hcB, hc);
         checkOutput("B_vcount", vcB, vc);
         checkOutput("B_ls", lsB, (hc == 0) ? 1 : 0);
         checkOutput("B_fs", fsB, (hc == 0 && vc == 0) ? 1 : 0);
         checkOutput("B_rgb", rgbB, expRgb);
         checkOutput("B_hs", hsB, expHs);
         checkOutput("B_vs", vsB, expVs);
      end

      // Small instance: mid-frame reset leaves no residue
      applyStimulus(1, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("B_mrst_hcount", hcB, 0);
      checkOutput("B_mrst_vcount", vcB, 0);
      checkOutput("B_mrst_tick", tickB, 0);
      checkOutput("B_mrst_rgb", rgbB, 0);
      checkOutput("B_mrst_hs", hsB, 0);
      checkOutput("B_mrst_vs", vsB, 0);
      applyStimulus(1, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("B_rel_fs", fsB, 1);
      repeat (3) @(negedge clk);
      checkOutput("B_rel_rgb", rgbB, 0);
      checkOutput("B_rel_hcount", hcB, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
